// File: rtl/uart_pkg.sv
// Shared definitions for the inverted-polarity UART transmitter:
// FSM state encoding, default word width and serial line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DATA_W = 8;

    // Line is inverted relative to RS-232: idle/stop low, start high.
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

    // Bit counter width; a 1-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// one bit per clock, with back-to-back frames while send stays high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] in,
    output logic              done,
    output logic              out
);

    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    uart_state_t       state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              out_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (send) begin
                    state_d = START;
                    shreg_d = in;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                shreg_d = shreg >> 1;
                cnt_d   = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (send) begin
                    state_d = START;
                    shreg_d = in;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered line
    // level lands in the same cycle the state is entered.
    always_comb begin
        out_d  = LINE_IDLE;
        done_d = 1'b0;
        case (state_d)
            START: out_d = LINE_START;
            DATA:  out_d = shreg_d[0];
            STOP: begin
                out_d  = LINE_STOP;
                done_d = 1'b1;
            end
            default: begin
                out_d  = LINE_IDLE;
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= LINE_IDLE;
            done <= 1'b0;
        end else begin
            out  <= out_d;
            done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: drives inputs on the falling edge and checks
// the serial line and done strobe on the following falling edges.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       send;
    logic [7:0] in;
    logic       done;
    logic       out;

    int testsRun;
    int testsFailed;
    int cycleCount;
    int doneCycle;

    uart_tx #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .send  (send),
        .in    (in),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d);
        send = s;
        in   = d;
    endtask

    task automatic checkIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.out%0d", tag, i), 32'(out), 32'd0);
            checkOutput($sformatf("%s.done%0d", tag, i), 32'(done), 32'd0);
        end
    endtask

    // Checks one full frame starting at the next falling edge; inputs for the
    // following edge are applied during the stop cycle, like a real client.
    task automatic checkFrame(input string tag, input logic [7:0] w, input bit midEn,
                              input logic [7:0] stopIn, input logic stopSend);
        @(negedge clk);
        checkOutput({tag, ".start"}, 32'(out), 32'd1);
        checkOutput({tag, ".startDone"}, 32'(done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.bit%0d", tag, k), 32'(out), 32'(w[k]));
            checkOutput($sformatf("%s.bitDone%0d", tag, k), 32'(done), 32'd0);
            if (midEn && k == 2) applyStimulus(1'b0, ~w);
        end
        @(negedge clk);
        checkOutput({tag, ".stop"}, 32'(out), 32'd0);
        checkOutput({tag, ".stopDone"}, 32'(done), 32'd1);
        doneCycle = cycleCount;
        applyStimulus(stopSend, stopIn);
    endtask

    logic [9:0] expSeq;
    int         t0;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        cycleCount  = 0;
        doneCycle   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00);

        // Reset and idle
        repeat (2) @(negedge clk);
        checkOutput("rst.out", 32'(out), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        checkIdle("idle", 3);

        // Single frame of A9, line sequence written out by hand
        expSeq = 10'b1_1001_0101_0;
        applyStimulus(1'b1, 8'hA9);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) applyStimulus(1'b0, 8'hA9);
            checkOutput($sformatf("single.out%0d", i), 32'(out), 32'(expSeq[9-i]));
            checkOutput($sformatf("single.done%0d", i), 32'(done), (i == 9) ? 32'd1 : 32'd0);
        end
        checkIdle("single.after", 2);

        // Back-to-back CA then D2, no idle gap
        applyStimulus(1'b1, 8'hCA);
        checkFrame("b2b0", 8'hCA, 1'b0, 8'hD2, 1'b1);
        checkFrame("b2b1", 8'hD2, 1'b0, 8'h00, 1'b0);
        checkIdle("b2b.after", 2);

        // Handshake stream A1, B2, C3 with done pulses 10 cycles apart
        applyStimulus(1'b1, 8'hA1);
        checkFrame("hs0", 8'hA1, 1'b0, 8'hB2, 1'b1);
        t0 = doneCycle;
        checkFrame("hs1", 8'hB2, 1'b0, 8'hC3, 1'b1);
        checkOutput("hs.gap1", 32'(doneCycle - t0), 32'd10);
        t0 = doneCycle;
        checkFrame("hs2", 8'hC3, 1'b0, 8'h00, 1'b0);
        checkOutput("hs.gap2", 32'(doneCycle - t0), 32'd10);
        checkIdle("hs.after", 2);

        // send dropped and in changed during DATA: original word completes
        applyStimulus(1'b1, 8'h5C);
        checkFrame("mid", 8'h5C, 1'b1, 8'h00, 1'b0);
        checkIdle("mid.after", 3);

        // Reset asserted at data bit 4
        applyStimulus(1'b1, 8'hB6);
        repeat (6) @(negedge clk);
        checkOutput("rstmid.bit4", 32'(out), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid.out", 32'(out), 32'd0);
        checkOutput("rstmid.done", 32'(done), 32'd0);
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        checkIdle("rstmid.idle", 3);
        applyStimulus(1'b1, 8'h3C);
        checkFrame("rstmid.frame", 8'h3C, 1'b0, 8'h00, 1'b0);
        checkIdle("rstmid.after", 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
